// File: rtl/pc_gen_if.sv
// -----------------------------------------------------------------------------
// pc_gen_if
//   Bundle of every signal between the program-counter generator and the rest
//   of the fetch stage. clk and rstn are kept outside as plain ports.
//
//   Fields:
//     trap_valid, trap_vec       trap/exception redirect and its target
//     redir_valid, redir_addr    prioritised redirect channels; channel i's
//                                target is redir_addr[i*XLEN +: XLEN]
//     stall                      pipeline hazard stall
//     ras_push, ras_pop          the instruction at pc_o is a call / a return
//     ins_len2                   the instruction at pc_o is 16 bits long
//     pc_ready                   the fetch unit accepts pc_o
//     pc_o, pc_valid             the current fetch address and its valid
//     ras_empty, ras_full        return-address-stack occupancy flags
//
//   Modports:
//     master  the PC generator (drives pc_o, pc_valid and the RAS flags)
//     slave   the pipeline / fetch side that drives everything else
// -----------------------------------------------------------------------------
interface pc_gen_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_REDIR = 2
);
    logic                      trap_valid;
    logic [XLEN-1:0]           trap_vec;
    logic [NUM_REDIR-1:0]      redir_valid;
    logic [NUM_REDIR*XLEN-1:0] redir_addr;
    logic                      stall;
    logic                      ras_push;
    logic                      ras_pop;
    logic                      ins_len2;
    logic                      pc_ready;
    logic [XLEN-1:0]           pc_o;
    logic                      pc_valid;
    logic                      ras_empty;
    logic                      ras_full;

    modport master (
        input  trap_valid, trap_vec, redir_valid, redir_addr, stall,
               ras_push, ras_pop, ins_len2, pc_ready,
        output pc_o, pc_valid, ras_empty, ras_full
    );

    modport slave (
        output trap_valid, trap_vec, redir_valid, redir_addr, stall,
               ras_push, ras_pop, ins_len2, pc_ready,
        input  pc_o, pc_valid, ras_empty, ras_full
    );
endinterface

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
//   Fetch-stage program-counter generator. Every clock edge it selects the next
//   fetch address from (highest priority first): trap vector, redirect channel
//   0 .. NUM_REDIR-1, stall hold, and on an accepted fetch either the
//   return-address-stack prediction or the sequential increment. It presents
//   the address to the I-fetch through a valid/ready handshake.
//
//   Ports:
//     clk    clock
//     rstn   asynchronous active-low reset
//     bus    pc_gen_if.master: redirect/stall/RAS hints in, pc_o/pc_valid and
//            RAS flags out
//
//   Parameters:
//     XLEN       address width
//     RESET_VEC  pc_o value held through reset and on the first valid cycle
//     NUM_REDIR  number of redirect channels, channel 0 has highest priority
//     RAS_DEPTH  return-address-stack entries (power of two, >= 2)
//     RVC_EN     1 allows a 2-byte increment for compressed instructions
// -----------------------------------------------------------------------------
module pc_gen #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     NUM_REDIR = 2,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter bit              RVC_EN    = 1'b0
) (
    input  logic     clk,
    input  logic     rstn,
    pc_gen_if.master bus
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Redirect targets are aligned to the smallest legal instruction size:
    // halfword with compressed support, word without it.
    localparam logic [XLEN-1:0] ALIGN_MASK = RVC_EN ? ~XLEN'(1) : ~XLEN'(3);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [XLEN-1:0]  pc_q,    pc_d;
    logic             valid_q, valid_d;
    // ptr points at the next free slot; the top of stack is ptr-1 (mod depth).
    logic [PTR_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [XLEN-1:0]  ras_q [RAS_DEPTH];

    // RAS write port, decided in the next-state logic
    logic             ras_we;
    logic [PTR_W-1:0] ras_waddr;
    logic [XLEN-1:0]  ras_wdata;

    // -------------------------------------------------------------------------
    // Derived values
    // -------------------------------------------------------------------------
    logic             fire;
    logic             ras_is_empty;
    logic             ras_is_full;
    logic             pop_hit;
    logic [PTR_W-1:0] top_idx;
    logic [XLEN-1:0]  ras_top;
    logic [XLEN-1:0]  seq_pc;
    logic             redir_any;
    logic [XLEN-1:0]  redir_tgt;

    assign fire         = valid_q & bus.pc_ready;
    assign ras_is_empty = (cnt_q == '0);
    assign ras_is_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign pop_hit      = bus.ras_pop & ~ras_is_empty;
    assign top_idx      = ptr_q - PTR_W'(1);
    assign ras_top      = ras_q[top_idx];
    assign redir_any    = |bus.redir_valid;

    // Sequential successor; natural modulo-2^XLEN wrap of the adder.
    assign seq_pc = pc_q + ((RVC_EN && bus.ins_len2) ? XLEN'(2) : XLEN'(4));

    // Lowest-numbered active channel wins: scanning downwards lets the lower
    // index overwrite any higher one found earlier.
    always_comb begin
        redir_tgt = '0;
        for (int i = int'(NUM_REDIR) - 1; i >= 0; i--) begin
            if (bus.redir_valid[i]) begin
                redir_tgt = bus.redir_addr[i*XLEN +: XLEN];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        pc_d      = pc_q;
        valid_d   = 1'b1;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ras_we    = 1'b0;
        ras_waddr = ptr_q;
        ras_wdata = seq_pc;

        if (!valid_q) begin
            // First edge out of reset only raises pc_valid; RESET_VEC is
            // presented to fetch before anything may move the PC.
        end else if (bus.trap_valid) begin
            // Redirects flush the instruction at pc_o, so its RAS hints die.
            pc_d = bus.trap_vec & ALIGN_MASK;
        end else if (redir_any) begin
            pc_d = redir_tgt & ALIGN_MASK;
        end else if (bus.stall) begin
            // Hold PC and RAS.
        end else if (fire) begin
            if (pop_hit) begin
                pc_d = ras_top;
                if (bus.ras_push) begin
                    // Call-return in one instruction: swap the top in place.
                    ras_we    = 1'b1;
                    ras_waddr = top_idx;
                end else begin
                    ptr_d = ptr_q - PTR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else begin
                // Also covers a pop on an empty stack: no prediction.
                pc_d = seq_pc;
                if (bus.ras_push) begin
                    // When full, ptr already points at the oldest entry, so
                    // the write overwrites it and the count saturates.
                    ras_we = 1'b1;
                    ptr_d  = ptr_q + PTR_W'(1);
                    if (!ras_is_full) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the stack storage has no reset; cnt_q gates every read, so stale
    // entries are never used and the array can map to plain registers/RAM.
    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_q[ras_waddr] <= ras_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.pc_o      = pc_q;
    assign bus.pc_valid  = valid_q;
    assign bus.ras_empty = ras_is_empty;
    assign bus.ras_full  = ras_is_full;

endmodule
